vend_dispense_arbiter: RTL and testbench

Shares one dispense motor and one change-payout unit among `N_PANELS` customer front panels. Each panel runs its own credit/selection logic and raises a request carrying the item code and change owed. This block grants one panel at a time in round-robin order, then runs the sequence: start motor, wait for completion with a timeout, pay change, report done or fault. It sits between the per-panel vending controllers and the shared mechanical actuators.

---
 rtl/vend_dispense_arbiter_if.sv | 33 +++
 rtl/vend_dispense_arbiter.sv | 125 ++++++++++++
 tb/tb_vend_dispense_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_dispense_arbiter_if.sv
// Signal bundle joining the per-panel vending controllers and the shared
// motor / change-payout actuators to the dispense arbiter.
interface vend_dispense_arbiter_if #(
  parameter int N_PANELS = 4,
  parameter int ITEM_W   = 2,
  parameter int CHANGE_W = 6
);
  logic [N_PANELS-1:0]          i_req;
  logic [N_PANELS*ITEM_W-1:0]   i_item;
  logic [N_PANELS*CHANGE_W-1:0] i_change;
  logic [N_PANELS-1:0]          o_grant;
  logic [N_PANELS-1:0]          o_done;
  logic [N_PANELS-1:0]          o_fault;
  logic                         o_motor_start;
  logic [ITEM_W-1:0]            o_motor_item;
  logic                         i_motor_done;
  logic                         o_change_valid;
  logic [CHANGE_W-1:0]          o_change_amt;
  logic                         i_change_ready;
  logic                         o_busy;

  modport master (
    input  i_req, i_item, i_change, i_motor_done, i_change_ready,
    output o_grant, o_done, o_fault, o_motor_start, o_motor_item,
           o_change_valid, o_change_amt, o_busy
  );

  modport slave (
    output i_req, i_item, i_change, i_motor_done, i_change_ready,
    input  o_grant, o_done, o_fault, o_motor_start, o_motor_item,
           o_change_valid, o_change_amt, o_busy
  );
endinterface

// File: rtl/vend_dispense_arbiter.sv
// Round-robin owner of the shared dispense motor and change payout unit:
// grants one panel, runs start / wait-with-timeout / pay, then reports done or fault.
module vend_dispense_arbiter #(
  parameter int N_PANELS      = 4,
  parameter int ITEM_W        = 2,
  parameter int CHANGE_W      = 6,
  parameter int MOTOR_TIMEOUT = 255
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  vend_dispense_arbiter_if.master bus
);

  localparam int          IDX_W      = (N_PANELS > 1) ? $clog2(N_PANELS) : 1;
  localparam logic [15:0] TIMER_LAST = 16'(MOTOR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_PAY,
    S_DONE,
    S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic [N_PANELS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [ITEM_W-1:0]   item_q, item_d;
  logic [CHANGE_W-1:0] change_q, change_d;
  logic [15:0]         timer_q, timer_d;

  logic                pickFound;
  logic [IDX_W-1:0]    pickIdx;
  logic [IDX_W-1:0]    cand;

  // Search starts just after the last served panel, so it sits at lowest priority.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_PANELS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % N_PANELS);
      if (!pickFound && bus.i_req[cand]) begin
        pickFound = 1'b1;
        pickIdx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    last_d   = last_q;
    item_d   = item_q;
    change_d = change_q;
    timer_d  = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (pickFound) begin
          state_d  = S_START;
          idx_d    = pickIdx;
          grant_d  = {{(N_PANELS-1){1'b0}}, 1'b1} << pickIdx;
          item_d   = bus.i_item[pickIdx*ITEM_W +: ITEM_W];
          change_d = bus.i_change[pickIdx*CHANGE_W +: CHANGE_W];
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      // A motor completion on the terminal timer cycle still counts as success.
      S_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (bus.i_motor_done) begin
          state_d = (change_q != '0) ? S_PAY : S_DONE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_PAY: begin
        if (bus.i_change_ready) state_d = S_DONE;
      end
      S_DONE, S_FAULT: begin
        last_d  = idx_q;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      last_q   <= IDX_W'(N_PANELS - 1);
      item_q   <= '0;
      change_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      item_q   <= item_d;
      change_q <= change_d;
      timer_q  <= timer_d;
    end
  end

  // Pulses are decoded from registered state so no input reaches an output combinationally.
  assign bus.o_grant        = grant_q;
  assign bus.o_done         = (state_q == S_DONE)  ? grant_q : '0;
  assign bus.o_fault        = (state_q == S_FAULT) ? grant_q : '0;
  assign bus.o_motor_start  = (state_q == S_START);
  assign bus.o_motor_item   = item_q;
  assign bus.o_change_valid = (state_q == S_PAY);
  assign bus.o_change_amt   = change_q;
  assign bus.o_busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// Self-checking bench for vend_dispense_arbiter: directed vector table, a reset
// abort sequence, and random transactions scored against a transaction-level model.
module tb_vend_dispense_arbiter;

  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int CW    = 6;
  localparam int TMO   = 8;
  localparam int IBITS = N * IW;
  localparam int CBITS = N * CW;
  localparam int NVEC  = 13;

  typedef struct {
    logic [N-1:0]     req;
    logic [IBITS-1:0] item;
    logic [CBITS-1:0] chg;
    int               d;
    bit               startDone;
    int               stall;
    bit               perturb;
  } stim_t;

  typedef struct {
    logic [N-1:0]     grant;
    int               endCyc;
    logic [N-1:0]     doneV;
    logic [N-1:0]     faultV;
    int               pay;
    logic [CW-1:0]    amt;
    logic [IW-1:0]    item;
    int               starts;
    bit               grantStable;
    bit               itemStable;
    bit               amtStable;
    bit               busyOk;
    logic [3*N+2:0]   after;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   lastServed = N - 1;

  vend_dispense_arbiter_if #(.N_PANELS(N), .ITEM_W(IW), .CHANGE_W(CW)) bus ();

  vend_dispense_arbiter #(
    .N_PANELS(N), .ITEM_W(IW), .CHANGE_W(CW), .MOTOR_TIMEOUT(TMO)
  ) dut (
    .i_clk   (clk),
    .i_resetn(resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic stim_t mkStim(logic [N-1:0] req, logic [IBITS-1:0] item,
                                   logic [CBITS-1:0] chg, int d, bit sd, int stall);
    stim_t s;
    s.req = req; s.item = item; s.chg = chg; s.d = d;
    s.startDone = sd; s.stall = stall; s.perturb = 1'b0;
    return s;
  endfunction

  function automatic obs_t mkExp(logic [N-1:0] g, int endC, logic [N-1:0] dv, logic [N-1:0] fv,
                                 int pay, logic [CW-1:0] amt, logic [IW-1:0] item);
    obs_t e;
    e = '{default: 0};
    e.grant = g; e.endCyc = endC; e.doneV = dv; e.faultV = fv;
    e.pay = pay; e.amt = amt; e.item = item; e.starts = 1;
    e.grantStable = 1'b1; e.itemStable = 1'b1; e.amtStable = 1'b1; e.busyOk = 1'b1;
    e.after = '0;
    return e;
  endfunction

  // Cycle 1 is the START cycle that follows the arbitration edge.
  task automatic applyStimulus(input stim_t s, output obs_t o);
    bit ended;
    o = '{default: 0};
    o.grantStable = 1'b1; o.itemStable = 1'b1; o.amtStable = 1'b1; o.busyOk = 1'b1;
    ended = 1'b0;
    bus.i_req = s.req; bus.i_item = s.item; bus.i_change = s.chg;
    bus.i_motor_done = 1'b0; bus.i_change_ready = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (ended) begin
        o.after = {bus.o_grant, bus.o_done, bus.o_fault, bus.o_busy,
                   bus.o_change_valid, bus.o_motor_start};
        break;
      end
      if (cyc == 1) begin
        o.grant = bus.o_grant;
        o.item  = bus.o_motor_item;
      end else begin
        if (bus.o_grant != o.grant) o.grantStable = 1'b0;
        if (bus.o_motor_item != o.item) o.itemStable = 1'b0;
      end
      if (!bus.o_busy) o.busyOk = 1'b0;
      if (bus.o_motor_start) o.starts++;
      if (bus.o_change_valid) begin
        if (o.pay == 0) o.amt = bus.o_change_amt;
        else if (bus.o_change_amt != o.amt) o.amtStable = 1'b0;
        o.pay++;
      end
      if ((bus.o_done | bus.o_fault) != '0) begin
        o.endCyc = cyc; o.doneV = bus.o_done; o.faultV = bus.o_fault;
        ended = 1'b1;
      end
      bus.i_motor_done   = (s.startDone && cyc == 1) || (s.d >= 0 && cyc == 2 + s.d);
      bus.i_change_ready = (s.d >= 0 && cyc >= 3 + s.d + s.stall);
      if (s.perturb) begin
        bus.i_req    = N'($urandom);
        bus.i_item   = IBITS'($urandom);
        bus.i_change = CBITS'($urandom);
      end
    end
    bus.i_motor_done = 1'b0;
    bus.i_change_ready = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input obs_t e, input obs_t a);
    compare({tag, ".grant"},       64'(a.grant),       64'(e.grant));
    compare({tag, ".endCycle"},    64'(a.endCyc),      64'(e.endCyc));
    compare({tag, ".done"},        64'(a.doneV),       64'(e.doneV));
    compare({tag, ".fault"},       64'(a.faultV),      64'(e.faultV));
    compare({tag, ".payCycles"},   64'(a.pay),         64'(e.pay));
    compare({tag, ".changeAmt"},   64'(a.amt),         64'(e.amt));
    compare({tag, ".motorItem"},   64'(a.item),        64'(e.item));
    compare({tag, ".motorStarts"}, 64'(a.starts),      64'(e.starts));
    compare({tag, ".grantStable"}, 64'(a.grantStable), 64'(e.grantStable));
    compare({tag, ".itemStable"},  64'(a.itemStable),  64'(e.itemStable));
    compare({tag, ".amtStable"},   64'(a.amtStable),   64'(e.amtStable));
    compare({tag, ".busy"},        64'(a.busyOk),      64'(e.busyOk));
    compare({tag, ".afterIdle"},   64'(a.after),       64'(e.after));
  endtask

  // Reference model: round-robin pick plus a closed-form transaction timeline.
  task automatic runModelTxn(input stim_t s, input string tag);
    int w;
    int endC;
    int pay;
    logic [CW-1:0] c;
    bit donePath;
    obs_t e;
    obs_t a;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && s.req[(lastServed + k) % N]) w = (lastServed + k) % N;
    end
    c = s.chg[w*CW +: CW];
    donePath = (s.d >= 0 && s.d < TMO);
    endC = donePath ? ((c != '0) ? 4 + s.d + s.stall : 3 + s.d) : 2 + TMO;
    pay = (donePath && c != '0) ? s.stall + 1 : 0;
    e = mkExp(N'(1) << w, endC,
              donePath ? N'(1) << w : '0,
              donePath ? '0 : N'(1) << w,
              pay, (pay > 0) ? c : '0, s.item[w*IW +: IW]);
    lastServed = w;
    applyStimulus(s, a);
    checkOutput(tag, e, a);
  endtask

  vec_t tbl[NVEC];

  initial begin
    obs_t a;
    stim_t s;

    // item code of panel p is p, so the latched item identifies the winner
    tbl[0]  = '{mkStim(4'b1010, 8'hE4, 24'h0, 1, 0, 0), mkExp(4'b0010, 4, 4'b0010, 4'b0000, 0, 0, 2'd1)};
    tbl[1]  = '{mkStim(4'b1010, 8'hE4, 24'h0, 1, 0, 0), mkExp(4'b1000, 4, 4'b1000, 4'b0000, 0, 0, 2'd3)};
    tbl[2]  = '{mkStim(4'b1111, 8'hE4, 24'h0, 0, 0, 0), mkExp(4'b0001, 3, 4'b0001, 4'b0000, 0, 0, 2'd0)};
    tbl[3]  = '{mkStim(4'b1111, 8'hE4, 24'h0, 0, 0, 0), mkExp(4'b0010, 3, 4'b0010, 4'b0000, 0, 0, 2'd1)};
    tbl[4]  = '{mkStim(4'b1111, 8'hE4, 24'h0, 0, 0, 0), mkExp(4'b0100, 3, 4'b0100, 4'b0000, 0, 0, 2'd2)};
    tbl[5]  = '{mkStim(4'b1111, 8'hE4, 24'h0, 0, 0, 0), mkExp(4'b1000, 3, 4'b1000, 4'b0000, 0, 0, 2'd3)};
    tbl[6]  = '{mkStim(4'b1111, 8'hE4, 24'h0, 0, 0, 0), mkExp(4'b0001, 3, 4'b0001, 4'b0000, 0, 0, 2'd0)};
    tbl[7]  = '{mkStim(4'b0100, 8'h30, 24'h014000, 0, 0, 5), mkExp(4'b0100, 9, 4'b0100, 4'b0000, 6, 6'd20, 2'd3)};
    tbl[8]  = '{mkStim(4'b0001, 8'hE4, 24'h00003F, -1, 0, 0), mkExp(4'b0001, 10, 4'b0000, 4'b0001, 0, 0, 2'd0)};
    tbl[9]  = '{mkStim(4'b0011, 8'hE4, 24'h0, 0, 0, 0), mkExp(4'b0010, 3, 4'b0010, 4'b0000, 0, 0, 2'd1)};
    tbl[10] = '{mkStim(4'b0100, 8'hE4, 24'h0, 7, 0, 0), mkExp(4'b0100, 10, 4'b0100, 4'b0000, 0, 0, 2'd2)};
    tbl[11] = '{mkStim(4'b1000, 8'hE4, 24'h0, 2, 1, 0), mkExp(4'b1000, 5, 4'b1000, 4'b0000, 0, 0, 2'd3)};
    tbl[12] = '{mkStim(4'b0001, 8'hE4, 24'h000005, 7, 0, 0), mkExp(4'b0001, 11, 4'b0001, 4'b0000, 1, 6'd5, 2'd0)};

    bus.i_req = '0; bus.i_item = '0; bus.i_change = '0;
    bus.i_motor_done = 1'b0; bus.i_change_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compare("reset.outputs",
            64'({bus.o_grant, bus.o_done, bus.o_fault, bus.o_motor_start, bus.o_motor_item,
                 bus.o_change_valid, bus.o_change_amt, bus.o_busy}), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(tbl[i].s, a);
      checkOutput($sformatf("vec%0d", i), tbl[i].e, a);
    end

    $display("[TB] reset during payout");
    bus.i_req = 4'b0010; bus.i_item = 8'hE4; bus.i_change = 24'(9) << CW;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_motor_done = 1'b1;
    @(posedge clk); #1;
    bus.i_motor_done = 1'b0;
    compare("midReset.payValid", 64'(bus.o_change_valid), 64'(1));
    compare("midReset.payAmt",   64'(bus.o_change_amt),   64'(9));
    #2;
    resetn = 1'b0;
    #1;
    compare("midReset.outputs",
            64'({bus.o_grant, bus.o_done, bus.o_fault, bus.o_motor_start, bus.o_motor_item,
                 bus.o_change_valid, bus.o_change_amt, bus.o_busy}), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    lastServed = N - 1;
    runModelTxn(mkStim(4'b1011, 8'hE4, 24'h0, 0, 0, 0), "postReset");

    $display("[TB] random transactions");
    for (int t = 0; t < 40; t++) begin
      int r;
      if ($urandom_range(0, 3) == 0) begin
        bus.i_req = '0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        compare($sformatf("gap%0d.idle", t), 64'({bus.o_busy, bus.o_grant}), 64'(0));
      end
      s.req = N'($urandom_range(1, (1 << N) - 1));
      s.item = IBITS'($urandom);
      s.chg = '0;
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 1) == 1) s.chg[p*CW +: CW] = CW'($urandom_range(1, (1 << CW) - 1));
      end
      r = $urandom_range(0, 9);
      if (r < 2) s.d = -1;
      else if (r < 4) s.d = TMO - 1;
      else if (r == 4) s.d = TMO;
      else s.d = $urandom_range(0, TMO - 2);
      s.startDone = ($urandom_range(0, 3) == 0);
      s.stall = $urandom_range(0, 4);
      s.perturb = ($urandom_range(0, 1) == 1);
      runModelTxn(s, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
